// File: rtl/limn2600_timer_if.sv
// limn2600_timer_if: CPU bus bundle for the timer.
// master drives cs/we/addr/data_in; slave returns data_out, rdy and irq.
interface limn2600_timer_if;
  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        rdy;
  logic        irq;
  modport master (output cs, we, addr, data_in, input data_out, rdy, irq);
  modport slave (input cs, we, addr, data_in, output data_out, rdy, irq);
endinterface

// File: rtl/limn2600_timer.sv
// limn2600_timer: memory-mapped interval timer with compare-match level interrupt.
// Ports: clk, rst (async active-high), bus (limn2600_timer_if.slave: cs, we, addr,
// data_in in; data_out, rdy, irq out). Registers: 0 COUNT, 1 COMPARE,
// 2 CTRL {reload, ie, en}, 3 STATUS {pend, write-1-to-clear}.
// Define LIMN2600_TIMER_PRESCALER_EN to tick once every PRESCALE enabled clocks.
module limn2600_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hF800_0000,
  parameter int          PRESCALE  = 16
) (
  input logic             clk,
  input logic             rst,
  limn2600_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t      state, state_n;
  logic [31:0] count, compare, rdata;
  logic [2:0]  ctrl;
  logic [1:0]  sel;
  logic        pend, tick, access, wr, match;
  logic        unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[1:0];
  assign sel    = bus.addr[3:2];
  assign access = state == IDLE && bus.cs && bus.addr[31:4] == BASE_ADDR[31:4];
  assign wr     = access && bus.we;
  // a COUNT write in the same edge as a tick overrides both increment and match
  assign match  = tick && !(wr && sel == 2'd0) && count == compare;
  assign rdata  = sel == 2'd0 ? count : sel == 2'd1 ? compare :
                  sel == 2'd2 ? {29'b0, ctrl} : {31'b0, pend};
  assign bus.rdy = state == ACK;
  assign bus.irq = pend & ctrl[1];
`ifdef LIMN2600_TIMER_PRESCALER_EN
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);
  logic [15:0] pre;
  assign tick = ctrl[0] && pre == PMAX;
  // restart the prescale period whenever the timer is switched on
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else if (wr && sel == 2'd2 && bus.data_in[0] && !ctrl[0]) pre <= '0;
    else if (ctrl[0]) pre <= tick ? '0 : pre + 16'd1;
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = ctrl[0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // ACK and WAIT both park in WAIT while cs is held, so one cs gives one access
  always_comb begin
    state_n = state == IDLE ? (access ? ACK : IDLE) : (bus.cs ? WAIT : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count        <= '0;
      compare      <= 32'hFFFF_FFFF;
      ctrl         <= '0;
      pend         <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (wr && sel == 2'd0) count <= bus.data_in;
      else if (tick) count <= match && ctrl[2] ? '0 : count + 32'd1;
      if (wr && sel == 2'd1) compare <= bus.data_in;
      if (wr && sel == 2'd2) ctrl <= bus.data_in[2:0];
      if (match) pend <= 1'b1;
      else if (wr && sel == 2'd3 && bus.data_in[0]) pend <= 1'b0;
      if (access && !bus.we) bus.data_out <= rdata;
    end
endmodule

// File: tb/tb_limn2600_timer.sv
// tb_limn2600_timer: directed plus randomized bus traffic checked against a register-level model.
module tb_limn2600_timer;
  localparam logic [31:0] BASE = 32'hF800_0000;
  localparam int PS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] m_count, m_cmp, m_rd;
  logic [2:0]  m_ctrl;
  logic        m_pend;
  int          m_pre;
  limn2600_timer_if bus();
  limn2600_timer #(.BASE_ADDR(BASE), .PRESCALE(PS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0; m_pend = 0; m_rd = 0; m_pre = 0;
  endtask

  function automatic logic [31:0] reg_val(input logic [1:0] s);
    case (s)
      2'd0: return m_count;
      2'd1: return m_cmp;
      2'd2: return {29'b0, m_ctrl};
      default: return {31'b0, m_pend};
    endcase
  endfunction

  // one clock edge: acc says whether the timer accepts the cycle on the bus this edge
  task automatic step(input bit acc);
    bit t, cw, m;
    logic [1:0] s;
    logic [31:0] d, rv;
    @(posedge clk);
    s = bus.addr[3:2];
    d = bus.data_in;
    t = 0;
    if (m_ctrl[0]) begin
`ifdef LIMN2600_TIMER_PRESCALER_EN
      if (m_pre == PS - 1) begin t = 1; m_pre = 0; end
      else m_pre++;
`else
      t = 1;
`endif
    end
    rv = reg_val(s);
    cw = acc && bus.we && s == 2'd0;
    m = t && !cw && m_count == m_cmp;
    if (cw) m_count = d;
    else if (t) m_count = (m && m_ctrl[2]) ? 0 : m_count + 1;
    if (m) m_pend = 1;
    else if (acc && bus.we && s == 2'd3 && d[0]) m_pend = 0;
    if (acc && bus.we && s == 2'd1) m_cmp = d;
    if (acc && bus.we && s == 2'd2) begin
      if (d[0] && !m_ctrl[0]) m_pre = 0;
      m_ctrl = d[2:0];
    end
    if (acc && !bus.we) m_rd = rv;
    @(negedge clk);
    chk("irq", {31'b0, bus.irq}, {31'b0, m_pend & m_ctrl[1]});
  endtask

  task automatic access(input bit w, input logic [1:0] s, input logic [31:0] d);
    bus.cs = 1; bus.we = w; bus.addr = BASE | {28'b0, s, 2'b0}; bus.data_in = d;
    step(1);
    chk("rdy_ack", {31'b0, bus.rdy}, 32'd1);
    chk(w ? "data_out_hold" : "read_data", bus.data_out, m_rd);
    bus.cs = 0;
    step(0);
    chk("rdy_after_ack", {31'b0, bus.rdy}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  initial begin
    int nr;
    bit done;
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.data_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rdy", {31'b0, bus.rdy}, 32'd0);
    chk("reset_irq", {31'b0, bus.irq}, 32'd0);
    chk("reset_data_out", bus.data_out, 32'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      access(0, 2'(i), 0);
      chk("reset_reg_value", bus.data_out, i == 1 ? 32'hFFFF_FFFF : 32'd0);
    end
    // basic compare match without reload
    access(1, 2'd1, 5);
    access(1, 2'd2, 3);
    idle(12);
    chk("match_irq", {31'b0, bus.irq}, 32'd1);
    access(0, 2'd0, 0);
    access(0, 2'd3, 0);
    chk("status_pend", bus.data_out, 32'd1);
    // reload mode
    access(1, 2'd2, 0);
    access(1, 2'd0, 0);
    access(1, 2'd1, 3);
    access(1, 2'd3, 1);
    chk("w1c_clear", {31'b0, bus.irq}, 32'd0);
    access(1, 2'd2, 7);
    idle(6);
    access(0, 2'd0, 0);
    idle(5);
    access(0, 2'd0, 0);
    // W1C landing on the same edge as a match keeps pend set
    access(1, 2'd3, 1);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (m_count == m_cmp && m_ctrl[0]
`ifdef LIMN2600_TIMER_PRESCALER_EN
          && m_pre == PS - 1
`endif
         ) done = 1;
      else step(0);
    end
    chk("align_match_found", {31'b0, done}, 32'd1);
    access(1, 2'd3, 1);
    chk("w1c_vs_match_pend", {31'b0, bus.irq}, 32'd1);
    // wrap through all-ones without flag, then match at 10
    access(1, 2'd2, 0);
    access(1, 2'd3, 1);
    access(1, 2'd0, 32'hFFFF_FFFE);
    access(1, 2'd1, 10);
    access(1, 2'd2, 3);
    idle(2);
    access(0, 2'd0, 0);
    access(0, 2'd3, 0);
    idle(50);
    access(0, 2'd0, 0);
    chk("wrap_then_match", {31'b0, bus.irq}, 32'd1);
    // held cs on a W1C gives a single access
    access(1, 2'd2, 2);
    bus.cs = 1; bus.we = 1; bus.addr = BASE | 32'hC; bus.data_in = 1;
    nr = 0;
    step(1);
    nr += bus.rdy;
    for (int i = 0; i < 5; i++) begin step(0); nr += bus.rdy; end
    bus.cs = 0;
    step(0);
    chk("hold_rdy_count", nr, 1);
    chk("hold_cleared", {31'b0, bus.irq}, 32'd0);
    // out-of-window access is ignored
    bus.cs = 1; bus.we = 1; bus.addr = BASE + 32'd16; bus.data_in = 7;
    nr = 0;
    for (int i = 0; i < 3; i++) begin step(0); nr += bus.rdy; end
    bus.cs = 0;
    step(0);
    chk("out_of_window_rdy", nr, 0);
    access(0, 2'd2, 0);
    // randomized traffic against the model
    for (int k = 0; k < 120; k++) begin
      logic [1:0] s;
      logic [31:0] d;
      bit w;
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = (s == 2'd0 || s == 2'd1) ? 32'($urandom_range(0, 24)) : $urandom;
      access(w, s, d);
      idle($urandom_range(0, 4));
    end
    // reset during ACK
    access(1, 2'd1, 2);
    access(1, 2'd2, 3);
    idle(20);
    bus.cs = 1; bus.we = 0; bus.addr = BASE; bus.data_in = 0;
    step(1);
    chk("pre_reset_rdy", {31'b0, bus.rdy}, 32'd1);
    rst = 1;
    #1;
    chk("async_reset_rdy", {31'b0, bus.rdy}, 32'd0);
    chk("async_reset_irq", {31'b0, bus.irq}, 32'd0);
    model_reset();
    bus.cs = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      access(0, 2'(i), 0);
      chk("post_reset_reg", bus.data_out, i == 1 ? 32'hFFFF_FFFF : 32'd0);
    end
    // steady counting: with the prescaler COUNT moves once per PS clocks
    access(1, 2'd2, 1);
    idle(13);
    access(0, 2'd0, 0);
    idle(7);
    access(0, 2'd0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
